// File: rtl/quantizer_1.sv
// -----------------------------------------------------------------------------
// quantizer_1
//
// Purpose:
//   Sequential JPEG-style quantizer. On start it walks N_COEF coefficients in
//   raster order, spending exactly four cycles on each one
//   (LOAD, COMPUTE, OUTPUT, ADVANCE). Each coefficient is divided by the
//   matching entry of the standard JPEG luminance table. A single DONE cycle
//   then returns the block to IDLE.
//
// Configuration macro:
//   QUANT_ROUND_EN - when defined, the division rounds half away from zero:
//                    sign(x) * floor((|x| + floor(Q/2)) / Q).
//                    When undefined (the default build), it truncates toward
//                    zero: sign(x) * floor(|x| / Q).
//                    Timing is the same in both builds.
//
// Ports:
//   clk        in   1               rising-edge clock
//   rst_n      in   1               asynchronous reset, ACTIVE-HIGH despite the
//                                   _n suffix
//   start      in   1               begins a block; only honoured in IDLE
//   dct_in     in   DATA_W signed   current coefficient, sampled in LOAD
//   quant_out  out  DATA_W signed   registered quantized coefficient
//   valid_out  out  1               one-cycle pulse when quant_out is new
//   done       out  1               one-cycle pulse after the last coefficient
//   q_monitor  out  Q_W             table divisor of the current coefficient
// -----------------------------------------------------------------------------
module quantizer_1 #(
    parameter int DATA_W = 16,
    parameter int Q_W    = 8,
    parameter int N_COEF = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic signed [DATA_W-1:0] dct_in,
    output logic signed [DATA_W-1:0] quant_out,
    output logic                     valid_out,
    output logic                     done,
    output logic        [Q_W-1:0]    q_monitor
);

    localparam int IDX_W = (N_COEF > 1) ? $clog2(N_COEF) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_COEF - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COMPUTE,
        S_OUTPUT,
        S_ADVANCE,
        S_DONE
    } state_t;

    // Standard JPEG luminance quantization table, row-major.
    localparam int Q_TABLE [64] = '{
         16,  11,  10,  16,  24,  40,  51,  61,
         12,  12,  14,  19,  26,  58,  60,  55,
         14,  13,  16,  24,  40,  57,  69,  56,
         14,  17,  22,  29,  51,  87,  80,  62,
         18,  22,  37,  56,  68, 109, 103,  77,
         24,  35,  55,  64,  81, 104, 113,  92,
         49,  64,  78,  87, 103, 121, 120, 101,
         72,  92,  95,  98, 112, 100, 103,  99
    };

    // Blocks longer than 64 coefficients reuse the table cyclically.
    function automatic logic [Q_W-1:0] q_lookup(input logic [IDX_W-1:0] idx);
        return Q_W'(Q_TABLE[int'(idx) % 64]);
    endfunction

    // The division works on the magnitude at DATA_W+1 bits, so that the most
    // negative input (for example -32768 at 16 bits) has a representable
    // absolute value. The sign is reapplied afterwards. The result is not
    // saturated.
    function automatic logic signed [DATA_W-1:0] quantize(
        input logic signed [DATA_W-1:0] x,
        input logic        [Q_W-1:0]    q
    );
        logic [DATA_W:0] mag;
        logic [DATA_W:0] num;
        logic [DATA_W:0] divisor;
        logic [DATA_W:0] quo;
        mag = {x[DATA_W-1], x};
        if (x[DATA_W-1]) begin
            mag = ~mag + (DATA_W+1)'(1);
        end
        divisor = (DATA_W+1)'(q);
`ifdef QUANT_ROUND_EN
        num = mag + (divisor >> 1);
`else
        num = mag;
`endif
        quo = num / divisor;
        if (x[DATA_W-1]) begin
            quo = ~quo + (DATA_W+1)'(1);
        end
        return DATA_W'(quo);
    endfunction

    state_t                     state_q,     state_d;
    logic        [IDX_W-1:0]    idx_q,       idx_d;
    logic signed [DATA_W-1:0]   x_q,         x_d;
    logic signed [DATA_W-1:0]   quant_out_q, quant_out_d;
    logic                       valid_out_q, valid_out_d;
    logic                       done_q,      done_d;
    logic        [Q_W-1:0]      q_monitor_q, q_monitor_d;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        x_d         = x_q;
        quant_out_d = quant_out_q;
        valid_out_d = 1'b0;
        done_d      = 1'b0;
        q_monitor_d = q_monitor_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    idx_d   = '0;
                end
            end
            S_LOAD: begin
                x_d         = dct_in;
                q_monitor_d = q_lookup(idx_q);
                state_d     = S_COMPUTE;
            end
            S_COMPUTE: begin
                // q_monitor_q already holds Q[idx], captured during LOAD.
                quant_out_d = quantize(x_q, q_monitor_q);
                valid_out_d = 1'b1;
                state_d     = S_OUTPUT;
            end
            S_OUTPUT: begin
                state_d = S_ADVANCE;
            end
            S_ADVANCE: begin
                if (idx_q < LAST_IDX) begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_LOAD;
                end else begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // start is deliberately not examined here.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            x_q         <= '0;
            quant_out_q <= '0;
            valid_out_q <= 1'b0;
            done_q      <= 1'b0;
            q_monitor_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            x_q         <= x_d;
            quant_out_q <= quant_out_d;
            valid_out_q <= valid_out_d;
            done_q      <= done_d;
            q_monitor_q <= q_monitor_d;
        end
    end

    assign quant_out = quant_out_q;
    assign valid_out = valid_out_q;
    assign done      = done_q;
    assign q_monitor = q_monitor_q;

endmodule

// File: tb/tb_quantizer_1.sv
module tb_quantizer_1;

    localparam int N = 64;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic signed [15:0] dct_in;
    logic signed [15:0] quant_out;
    logic               valid_out;
    logic               done;
    logic        [7:0]  q_monitor;

    int checks;
    int failures;

    int stim [N];
    int got  [N];
    int gotq [N];

    localparam int QTAB [64] = '{
         16,  11,  10,  16,  24,  40,  51,  61,
         12,  12,  14,  19,  26,  58,  60,  55,
         14,  13,  16,  24,  40,  57,  69,  56,
         14,  17,  22,  29,  51,  87,  80,  62,
         18,  22,  37,  56,  68, 109, 103,  77,
         24,  35,  55,  64,  81, 104, 113,  92,
         49,  64,  78,  87, 103, 121, 120, 101,
         72,  92,  95,  98, 112, 100, 103,  99
    };

    quantizer_1 #(.DATA_W(16), .Q_W(8), .N_COEF(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dct_in    (dct_in),
        .quant_out (quant_out),
        .valid_out (valid_out),
        .done      (done),
        .q_monitor (q_monitor)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    // Reference quantizer in plain integer arithmetic.
    function automatic int ref_quant(input int x, input int q);
        int m;
        int r;
        m = (x < 0) ? -x : x;
`ifdef QUANT_ROUND_EN
        r = (m + q / 2) / q;
`else
        r = m / q;
`endif
        return (x < 0) ? -r : r;
    endfunction

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic fill_random();
        logic signed [15:0] t;
        for (int k = 0; k < N; k++) begin
            if ($urandom_range(0, 1) == 1) begin
                t = 16'($urandom);
                stim[k] = int'(t);
            end else begin
                stim[k] = int'($urandom_range(0, 400)) - 200;
            end
        end
    endtask

    // Called at a falling edge with the DUT in IDLE. It returns at a falling
    // edge with the DUT back in IDLE.
    task automatic run_block(input int abort_at, input int pulse_at, input bit start_in_done);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < N; k++) begin
            // LOAD
            dct_in = 16'(stim[k]);
            if (k == pulse_at) start = 1'b1;
            check($sformatf("load_valid[%0d]", k), longint'(valid_out), 0);
            check($sformatf("load_done[%0d]", k), longint'(done), 0);
            @(negedge clk);
            start = 1'b0;
            // COMPUTE
            gotq[k] = int'(q_monitor);
            check($sformatf("qmon[%0d]", k), longint'(q_monitor), longint'(QTAB[k]));
            check($sformatf("comp_valid[%0d]", k), longint'(valid_out), 0);
            if (k == abort_at) begin
                rst_n = 1'b1;
                #1;
                check("abort_quant", longint'(quant_out), 0);
                check("abort_qmon", longint'(q_monitor), 0);
                check("abort_valid", longint'(valid_out), 0);
                check("abort_done", longint'(done), 0);
                @(negedge clk);
                rst_n = 1'b0;
                for (int c = 0; c < 8; c++) begin
                    @(negedge clk);
                    check("post_abort_done", longint'(done), 0);
                    check("post_abort_valid", longint'(valid_out), 0);
                end
                return;
            end
            @(negedge clk);
            // OUTPUT
            got[k] = int'(quant_out);
            check($sformatf("valid[%0d]", k), longint'(valid_out), 1);
            check($sformatf("quant[%0d]", k), longint'(quant_out),
                  longint'(ref_quant(stim[k], QTAB[k])));
            check($sformatf("out_done[%0d]", k), longint'(done), 0);
            @(negedge clk);
            // ADVANCE
            check($sformatf("adv_valid[%0d]", k), longint'(valid_out), 0);
            check($sformatf("adv_done[%0d]", k), longint'(done), 0);
            @(negedge clk);
        end
        // DONE
        if (start_in_done) start = 1'b1;
        check("done_pulse", longint'(done), 1);
        check("done_valid", longint'(valid_out), 0);
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 6; c++) begin
            check("idle_done", longint'(done), 0);
            check("idle_valid", longint'(valid_out), 0);
            check("idle_qmon_hold", longint'(q_monitor), longint'(QTAB[N-1]));
            check("idle_quant_hold", longint'(quant_out), longint'(got[N-1]));
            @(negedge clk);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b1;
        start    = 1'b0;
        dct_in   = '0;

        // Reset, then idle with start low.
        repeat (3) @(negedge clk);
        check("rst_quant", longint'(quant_out), 0);
        check("rst_qmon", longint'(q_monitor), 0);
        rst_n = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("idle_quant", longint'(quant_out), 0);
            check("idle_qmon", longint'(q_monitor), 0);
            check("idle_valid0", longint'(valid_out), 0);
            check("idle_done0", longint'(done), 0);
        end

        // Ramp block, dct[i] = 10*i - 320.
        for (int k = 0; k < N; k++) stim[k] = 10 * k - 320;
        run_block(-1, -1, 1'b0);
        check("ramp_q0", longint'(got[0]), -20);
        check("ramp_m0", longint'(gotq[0]), 16);
        check("ramp_q1", longint'(got[1]), -28);
        check("ramp_m1", longint'(gotq[1]), 11);
        check("ramp_q2", longint'(got[2]), -30);
        check("ramp_m2", longint'(gotq[2]), 10);
        check("ramp_q32", longint'(got[32]), 0);
        check("ramp_m32", longint'(gotq[32]), 18);
        check("ramp_q63", longint'(got[63]), 3);
        check("ramp_m63", longint'(gotq[63]), 99);

        // Random block, start pulsed at coefficient 10 and again during DONE.
        fill_random();
        run_block(-1, 10, 1'b1);

        // Rounding boundaries at index 0 (Q = 16).
        fill_random();
        stim[0] = 8;
        run_block(-1, -1, 1'b0);
`ifdef QUANT_ROUND_EN
        check("bnd_p8", longint'(got[0]), 1);
`else
        check("bnd_p8", longint'(got[0]), 0);
`endif
        fill_random();
        stim[0] = 7;
        run_block(-1, -1, 1'b0);
        check("bnd_p7", longint'(got[0]), 0);
        fill_random();
        stim[0] = -8;
        run_block(-1, -1, 1'b0);
`ifdef QUANT_ROUND_EN
        check("bnd_m8", longint'(got[0]), -1);
`else
        check("bnd_m8", longint'(got[0]), 0);
`endif
        fill_random();
        stim[0] = -32768;
        run_block(-1, -1, 1'b0);
        check("bnd_min", longint'(got[0]), -2048);

        // Reset during COMPUTE of coefficient 5, then a fresh block.
        fill_random();
        run_block(5, -1, 1'b0);
        fill_random();
        run_block(-1, -1, 1'b0);
        check("restart_m0", longint'(gotq[0]), 16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/quantizer_1.md
QUANTIZER_1 -- requirements
Module: quantizer_1

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the width of dct_in and quant_out (signed two's complement).
REQ-002 Parameter Q_W, default 8, SHALL set the width of quantization table entries and q_monitor.
REQ-003 Parameter N_COEF, default 64, SHALL set the number of coefficients per block.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  SHALL be the reset: asynchronous, active-high (asserted when 1), despite the _n suffix.
REQ-006 start  input  1  SHALL begin processing a block when sampled high in IDLE.
REQ-007 dct_in  input  DATA_W signed  SHALL carry the current DCT coefficient, raster order, sampled in LOAD.
REQ-008 quant_out  output  DATA_W signed  SHALL be the registered quantized coefficient.
REQ-009 valid_out  output  1  SHALL be high for exactly one cycle when quant_out holds a new result.
REQ-010 done  output  1  SHALL pulse high for one cycle after the last coefficient.
REQ-011 q_monitor  output  Q_W  SHALL show the table divisor used for the current coefficient.

Function
REQ-012 States SHALL be IDLE, LOAD, COMPUTE, OUTPUT, ADVANCE, DONE; encoding is free.
REQ-013 IDLE -> LOAD when start=1, with the coefficient index cleared to 0; otherwise stay in IDLE.
REQ-014 LOAD -> COMPUTE: capture dct_in; register Q[index] into q_monitor.
REQ-015 COMPUTE -> OUTPUT: compute quotient = captured dct_in / Q[index] per REQ-020; load it into quant_out; set valid_out=1.
REQ-016 OUTPUT -> ADVANCE: clear valid_out; hold quant_out.
REQ-017 ADVANCE -> LOAD with index+1 if index < N_COEF-1, else -> DONE.
REQ-018 DONE: done=1 for one cycle, then -> IDLE; quant_out and q_monitor hold their last values.
REQ-019 Throughput SHALL be exactly 4 cycles per coefficient (LOAD, COMPUTE, OUTPUT, ADVANCE), 256 cycles per block, plus the DONE cycle.
REQ-020 Division SHALL compute sign(x)*floor((|x| + floor(Q/2)) / Q), rounding half away from zero, with no saturation. |x| SHALL be computed at DATA_W+1 bits so that -32768 is handled.
REQ-021 Q table SHALL be the standard JPEG luminance table, row-major: 16 11 10 16 24 40 51 61 / 12 12 14 19 26 58 60 55 / 14 13 16 24 40 57 69 56 / 14 17 22 29 51 87 80 62 / 18 22 37 56 68 109 103 77 / 24 35 55 64 81 104 113 92 / 49 64 78 87 103 121 120 101 / 72 92 95 98 112 100 103 99.
REQ-022 start SHALL be ignored in every state except IDLE; a start sampled during DONE SHALL NOT be acted on.
REQ-023 valid_out and done SHALL never be high in the same cycle.

Reset
REQ-024 While rst_n=1, the block SHALL immediately force: state IDLE, index 0, quant_out 0, valid_out 0, done 0, q_monitor 0, captured input 0.
REQ-025 Reset asserted mid-block SHALL abort the block; the partial block SHALL NOT be resumed and done SHALL NOT pulse.

Configuration
REQ-026 Macro QUANT_ROUND_EN: when defined, division SHALL round per REQ-020; when undefined, division SHALL truncate toward zero (sign(x)*floor(|x|/Q)), with timing unchanged.

Verification
REQ-027 Reset then idle, start held 0 for 10 cycles -> all outputs 0, no valid_out, no done.
REQ-028 Block with dct[i]=10*i-320, one value presented per 4 cycles -> quant_out: i=0 -20 (q_monitor 16), i=1 -28 (Q 11), i=2 -30 (Q 10), i=32 0 (Q 18), i=63 3 (Q 99); 64 valid_out pulses spaced 4 cycles apart; done pulses once, 1 cycle after the final ADVANCE.
REQ-029 Rounding boundaries, index 0 (Q=16): dct 8 -> 1, dct 7 -> 0, dct -8 -> -1, dct -32768 -> -2048; with QUANT_ROUND_EN undefined, dct 8 -> 0.
REQ-030 start pulsed at coefficient 10 mid-block -> no restart; block completes at 64 coefficients with a single done.
REQ-031 rst_n asserted during COMPUTE of coefficient 5 -> outputs cleared asynchronously, no done; new start -> index restarts at 0 and q_monitor=16.
